step3_normalize: RTL and testbench

- Normalize-and-round stage of the single-precision floating-point MAC pipeline.
- Consumes the unnormalized sign/exponent/magnitude sum produced by the add stage.
- Produces an IEEE-754 packed sign/exponent/fraction with status flags.
- Its out_sign feeds step4_status directly.
- Two-stage pipeline; one result per cycle; no backpressure.

---
 rtl/step3_normalize.sv | 177 +++++++++++++++++
 tb/tb_step3_normalize.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step3_normalize.sv
// Normalize-and-round stage of the single-precision FP MAC pipeline.
// Stage A aligns the hidden bit, stage B rounds to nearest even and clamps the exponent.
module step3_normalize #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic                   in_sign,
    input  logic [EXP_W+1:0]       in_exp,
    input  logic [2*MAN_W+1:0]     in_mant,
    output logic                   out_valid,
    output logic                   out_sign,
    output logic [EXP_W-1:0]       out_exp,
    output logic [MAN_W-1:0]       out_mant,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_zero
);

    localparam int SUM_W   = 2*MAN_W + 2;
    localparam int H       = 2*MAN_W;
    localparam int EW      = EXP_W + 2;
    localparam int LZ_W    = $clog2(H + 1);
    localparam int EXP_INF = 2*BIAS + 1;

    localparam logic signed [EW:0] E_INF  = EW'(EXP_INF);
    localparam logic signed [EW:0] E_ZERO = '0;

    // Handshake: in_valid qualifies the input sample for one cycle; there is no
    // ready, so every valid sample is accepted. out_valid qualifies all outputs.

    // ------------------------------------------------------------------
    // Stage A: leading-zero count and normalization (combinational part)
    // ------------------------------------------------------------------
    logic [LZ_W-1:0]  lz;
    logic [SUM_W-1:0] mant_shr;
    logic [SUM_W-1:0] mant_shl;
    logic             a_zero_n;
    logic             a_sticky_n;
    logic [H:0]       a_norm_n;
    logic [EW-1:0]    a_exp_n;

    always_comb begin
        lz = '0;
        // Ascending scan: the highest set bit at or below the hidden position wins.
        for (int i = 0; i <= H; i++) begin
            if (in_mant[i]) begin
                lz = LZ_W'(H - i);
            end
        end
    end

    assign mant_shr = in_mant >> 1;
    assign mant_shl = in_mant << lz;

    always_comb begin
        a_zero_n   = 1'b0;
        a_sticky_n = 1'b0;
        a_norm_n   = '0;
        a_exp_n    = in_exp;
        if (in_mant == '0) begin
            a_zero_n = 1'b1;
        end else if (in_mant[SUM_W-1]) begin
            a_norm_n   = mant_shr[H:0];
            a_exp_n    = in_exp + EW'(1);
            a_sticky_n = in_mant[0];
        end else begin
            a_norm_n = mant_shl[H:0];
            a_exp_n  = in_exp - EW'(lz);
        end
    end

    // Stage A registers; the normalized value always has bit H set (or is zero),
    // so the carry position is not carried forward.
    logic          a_valid;
    logic          a_sign;
    logic          a_zero;
    logic          a_sticky;
    logic [H:0]    a_norm;
    logic [EW-1:0] a_exp;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_valid  <= 1'b0;
            a_sign   <= 1'b0;
            a_zero   <= 1'b0;
            a_sticky <= 1'b0;
            a_norm   <= '0;
            a_exp    <= '0;
        end else begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_sign   <= in_sign;
                a_zero   <= a_zero_n;
                a_sticky <= a_sticky_n;
                a_norm   <= a_norm_n;
                a_exp    <= a_exp_n;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: round to nearest even, then clamp the exponent
    // ------------------------------------------------------------------
    logic [MAN_W-1:0]  frac;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MAN_W:0]    frac_sum;
    logic signed [EW:0] e_fin;

    assign frac     = a_norm[H-1:MAN_W];
    assign guard    = a_norm[MAN_W-1];
    assign sticky   = (|a_norm[MAN_W-2:0]) | a_sticky;
    assign round_up = guard & (sticky | frac[0]);
    assign frac_sum = {1'b0, frac} + (MAN_W+1)'(round_up);
    // One extra bit keeps the round carry from wrapping the signed exponent.
    assign e_fin    = $signed({a_exp[EW-1], a_exp}) + $signed((EW+1)'(frac_sum[MAN_W]));

    logic             b_sign_n;
    logic [EXP_W-1:0] b_exp_n;
    logic [MAN_W-1:0] b_mant_n;
    logic             b_ovf_n;
    logic             b_unf_n;
    logic             b_zero_n;

    always_comb begin
        b_sign_n = a_sign;
        b_exp_n  = e_fin[EXP_W-1:0];
        b_mant_n = frac_sum[MAN_W-1:0];
        b_ovf_n  = 1'b0;
        b_unf_n  = 1'b0;
        b_zero_n = 1'b0;
        if (a_zero) begin
            // Exact cancellation is reported as +0.
            b_sign_n = 1'b0;
            b_exp_n  = '0;
            b_mant_n = '0;
            b_zero_n = 1'b1;
        end else if (e_fin >= E_INF) begin
            b_exp_n  = EXP_W'(EXP_INF);
            b_mant_n = '0;
            b_ovf_n  = 1'b1;
        end else if (e_fin <= E_ZERO) begin
            b_exp_n  = '0;
            b_mant_n = '0;
            b_unf_n  = 1'b1;
            b_zero_n = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid     <= 1'b0;
            out_sign      <= 1'b0;
            out_exp       <= '0;
            out_mant      <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_zero      <= 1'b0;
        end else begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_sign      <= b_sign_n;
                out_exp       <= b_exp_n;
                out_mant      <= b_mant_n;
                out_overflow  <= b_ovf_n;
                out_underflow <= b_unf_n;
                out_zero      <= b_zero_n;
            end
        end
    end

endmodule

// File: tb/tb_step3_normalize.sv
// Directed-vector bench for step3_normalize: one task per scenario with inline checks.
// Result compared as {valid, sign, exp[7:0], mant[22:0], overflow, underflow, zero}.
module tb_step3_normalize;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    logic [35:0] obs;
    logic [35:0] want;

    assign obs = {out_valid, out_sign, out_exp, out_mant, out_overflow, out_underflow, out_zero};

    step3_normalize dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_sign      (out_sign),
        .out_exp       (out_exp),
        .out_mant      (out_mant),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_zero      (out_zero)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------
    // Present one input at the falling edge; return just after the sampling rising edge.
    task automatic drive(input logic v, input logic s, input logic [9:0] e, input logic [47:0] m);
        @(negedge clock);
        in_valid = v;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(posedge clock);
    endtask

    // One isolated sample; returns #1 after the edge where its result is registered.
    task automatic run_one(input logic s, input logic [9:0] e, input logic [47:0] m);
        drive(1'b1, s, e, m);
        drive(1'b0, 1'b0, 10'd0, 48'd0);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = '0;
        in_mant  = '0;
        resetn   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (obs !== 36'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs, 36'd0);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (obs !== 36'd0) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", obs, 36'd0);
        end
    endtask

    task automatic test_basic();
        run_one(1'b0, 10'd127, 48'h4000_0000_0000);
        want = {1'b1, 1'b0, 8'd127, 23'd0, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL basic_one: got %h want %h", obs, want);
        end
    endtask

    task automatic test_carry();
        run_one(1'b0, 10'd127, 48'h8000_0000_0000);
        want = {1'b1, 1'b0, 8'd128, 23'd0, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL carry_plain: got %h want %h", obs, want);
        end
        // Shifted-out bit 0 becomes sticky, turning a tie into a round-up.
        run_one(1'b1, 10'd127, 48'h8000_0080_0001);
        want = {1'b1, 1'b1, 8'd128, 23'd1, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL carry_sticky: got %h want %h", obs, want);
        end
    endtask

    task automatic test_cancel();
        run_one(1'b0, 10'd150, 48'h0000_0080_0000);
        want = {1'b1, 1'b0, 8'd127, 23'd0, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL cancel_lz23: got %h want %h", obs, want);
        end
        run_one(1'b0, 10'd200, 48'h0000_0000_0001);
        want = {1'b1, 1'b0, 8'd154, 23'd0, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL cancel_lz46: got %h want %h", obs, want);
        end
    endtask

    task automatic test_round();
        run_one(1'b0, 10'd127, 48'h4000_0040_0000);
        want = {1'b1, 1'b0, 8'd127, 23'd0, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL round_tie_even: got %h want %h", obs, want);
        end
        run_one(1'b0, 10'd127, 48'h4000_00C0_0000);
        want = {1'b1, 1'b0, 8'd127, 23'd2, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL round_tie_odd: got %h want %h", obs, want);
        end
        run_one(1'b0, 10'd127, 48'h4000_0060_0000);
        want = {1'b1, 1'b0, 8'd127, 23'd1, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL round_above_half: got %h want %h", obs, want);
        end
        run_one(1'b0, 10'd127, 48'h7FFF_FFC0_0000);
        want = {1'b1, 1'b0, 8'd128, 23'd0, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL round_carry: got %h want %h", obs, want);
        end
    endtask

    task automatic test_clamp();
        run_one(1'b1, 10'd254, 48'h8000_0000_0000);
        want = {1'b1, 1'b1, 8'd255, 23'd0, 3'b100};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL clamp_overflow: got %h want %h", obs, want);
        end
        run_one(1'b0, 10'd254, 48'h7FFF_FFC0_0000);
        want = {1'b1, 1'b0, 8'd255, 23'd0, 3'b100};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL clamp_round_overflow: got %h want %h", obs, want);
        end
        run_one(1'b1, 10'd1, 48'h2000_0000_0000);
        want = {1'b1, 1'b1, 8'd0, 23'd0, 3'b011};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL clamp_underflow: got %h want %h", obs, want);
        end
        run_one(1'b1, 10'd127, 48'd0);
        want = {1'b1, 1'b0, 8'd0, 23'd0, 3'b001};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL clamp_zero_input: got %h want %h", obs, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp_q[$];
        exp_q.push_back({1'b1, 1'b1, 8'd127, 23'd0, 3'b000});
        exp_q.push_back({1'b1, 1'b0, 8'd130, 23'd2, 3'b000});
        exp_q.push_back({1'b0, 35'd0});
        exp_q.push_back({1'b1, 1'b0, 8'd101, 23'd0, 3'b000});

        drive(1'b1, 1'b1, 10'd127, 48'h4000_0000_0000);
        drive(1'b1, 1'b0, 10'd130, 48'h4000_00C0_0000);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL stream_s1: got %h want %h", obs, want);
        end
        drive(1'b0, 1'b0, 10'd0, 48'd0);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL stream_s2: got %h want %h", obs, want);
        end
        drive(1'b1, 1'b0, 10'd100, 48'h8000_0000_0000);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (out_valid !== want[35]) begin
            errors++;
            $display("FAIL stream_bubble: got valid %b want %b", out_valid, want[35]);
        end
        drive(1'b1, 1'b0, 10'd150, 48'h0000_0080_0000);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL stream_s3: got %h want %h", obs, want);
        end

        // s4 sits in stage A, s5 is on the inputs: reset mid-cycle.
        @(negedge clock);
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 10'd200;
        in_mant  = 48'h4000_0000_0000;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (obs !== 36'd0) begin
            errors++;
            $display("FAIL stream_async_reset: got %h want %h", obs, 36'd0);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_no_stale_%0d: got valid %b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_after_reset();
        run_one(1'b0, 10'd128, 48'h4000_0060_0000);
        want = {1'b1, 1'b0, 8'd128, 23'd1, 3'b000};
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL after_reset: got %h want %h", obs, want);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_cancel();
        test_round();
        test_clamp();
        test_back_to_back();
        test_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
